hi5_fetch: RTL
==============

# hi5_fetch

Instruction fetch stage for the HI5 pipeline. Sequentially reads 36-bit HI5 instruction words from a fixed-latency instruction memory, buffers them in a small prefetch FIFO, and presents them one per cycle over a valid/ready handshake to the opcode-decode/register-write stage (consumer of `code`). Supports a redirect (jump) that flushes all buffered and in-flight words and restarts fetch at a new address.

## Interface
- `ADDR_W`, 16, instruction word address width
- `DEPTH`, 4, prefetch FIFO entries; power of two, ≥ 2
- `RESET_PC`, 0, first fetch address after reset
- `clock`  in  1  single clock; all state on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `mem_req`  out  1  read strobe to instruction memory
- `mem_addr`  out  ADDR_W  word address for `mem_req`
- `mem_rdata`  in  36  read data; valid exactly 1 cycle after the `mem_req` cycle
- `redirect`  in  1  one-cycle pulse: flush and restart fetch
- `redirect_pc`  in  ADDR_W  new fetch address, sampled when `redirect`=1
- `code_valid`  out  1  `code`/`code_pc` hold a valid instruction
- `code`  out  36  HI5 instruction word to decode
- `code_pc`  out  ADDR_W  address `code` was fetched from
- `code_ready`  in  1  downstream accepts `code` this cycle
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- State: `pc` (next fetch address), `inflight` (1 bit: request issued last cycle, data returns this cycle), `inflight_pc`, FIFO of {pc, word} with rd/wr pointers and count.
- Issue: `mem_req`=1, `mem_addr`=`pc` when `reset_n`=1, `redirect`=0, and `count + inflight < DEPTH` (pop in same cycle not credited). On issue: `pc` ← `pc`+1, wrapping 2^ADDR_W−1 → 0; `inflight` ← 1, `inflight_pc` ← `pc`. Else `inflight` ← 0.
- Return: when `inflight`=1 and `redirect`=0, push {`inflight_pc`, `mem_rdata`}. Credit rule guarantees the FIFO is never full at push.
- Pop: `code_valid`&&`code_ready` advances rd pointer. Push and pop in the same cycle: count unchanged, both performed.
- Output: `code_valid` = (count≠0); `code`/`code_pc` = FIFO head (registered storage, no combinational path from `mem_rdata`). When `code_valid`=0, `code`=0, `code_pc`=0.
- Redirect (priority over everything except reset): count ← 0, pointers ← 0, data returning this cycle dropped, no request this cycle, `inflight` ← 0, `pc` ← `redirect_pc`. A handshake completing in the redirect cycle counts as consumed by downstream; all other entries are discarded.
- `code_ready` with `code_valid`=0 has no effect. `code`/`code_pc` stable while `code_valid`=1 and `code_ready`=0.

## Timing
- Reset (`reset_n`=0 at an edge): `pc` ← RESET_PC, count/pointers/`inflight` ← 0. Outputs during and immediately after reset: `mem_req`=0, `mem_addr`=0 when `mem_req`=0, `code_valid`=0, `code`=0, `code_pc`=0, `level`=0. Reset mid-stream discards in-flight data identically to redirect.
- First `mem_req` (addr RESET_PC) in the first cycle with `reset_n`=1; that word is pushed at the next edge, so `code_valid`=1 two cycles after reset release.
- Redirect latency: redirect at cycle T → `mem_req` to `redirect_pc` at T+1 → `code_valid` with that word at T+3 (visible after edge ending T+2).
- Throughput: 1 instruction/cycle sustained with `code_ready` held high.
- Backpressure: with `code_ready`=0, fetch stops once count+inflight reaches DEPTH; `level` settles at DEPTH; resumes issuing the cycle after a pop lowers count+inflight below DEPTH.

## Test plan
- Reset release, memory word(i) = {4'hA, 32'h1000_0000+i}, `code_ready`=1 → `code_valid` rises 2 cycles after release; codes for addresses 0,1,2,… in order, one per cycle, no gaps; `code_pc` matches.
- `code_ready`=0 from release → exactly DEPTH=4 requests (addr 0–3), `level`=4, `mem_req`=0 thereafter; raise `code_ready` → words 0,1,2,3,4,… delivered without loss or duplication.
- Redirect to 0x0100 while FIFO holds 3 entries and a read is in flight → `level`=0 next cycle, stale word not delivered, next delivered `code_pc`=0x0100 at T+3, then 0x0101.
- RESET_PC=16'hFFFE → delivered `code_pc` sequence FFFE, FFFF, 0000, 0001.
- Alternating `code_ready` (1,0,1,0…) for 20 cycles → every address delivered exactly once in order; `level` never exceeds 4; `code` stable while stalled.
- `reset_n`=0 for one cycle mid-stream with FIFO full → all outputs 0 next cycle; fetch restarts at RESET_PC, no pre-reset word appears.

Source files
------------

// File: rtl/hi5_fetch_if.sv
// Fetch-stage bus: instruction-memory read port, redirect input, and the
// valid/ready instruction stream toward decode.
interface hi5_fetch_if #(
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 4
);
   logic                      mem_req;
   logic [ADDR_W-1:0]         mem_addr;
   logic [35:0]               mem_rdata;
   logic                      redirect;
   logic [ADDR_W-1:0]         redirect_pc;
   logic                      code_valid;
   logic [35:0]               code;
   logic [ADDR_W-1:0]         code_pc;
   logic                      code_ready;
   logic [$clog2(DEPTH):0]    level;

   modport master (
      output mem_req, mem_addr, code_valid, code, code_pc, level,
      input  mem_rdata, redirect, redirect_pc, code_ready
   );

   modport slave (
      input  mem_req, mem_addr, code_valid, code, code_pc, level,
      output mem_rdata, redirect, redirect_pc, code_ready
   );
endinterface

// File: rtl/hi5_fetch.sv
// HI5 instruction fetch: sequential reads from a 1-cycle-latency memory into a
// small prefetch FIFO, streamed to decode, with redirect flush/restart.
module hi5_fetch #(
   parameter int                ADDR_W   = 16,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic      clock,
   input  logic      reset_n,
   hi5_fetch_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] inflight_pc;
   logic              inflight;
   logic [CW-1:0]     count;
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [35:0]       word_q [DEPTH];
   logic [ADDR_W-1:0] pc_q   [DEPTH];

   logic issue;
   logic push;
   logic pop;
   logic head_valid;

   // Credit counts the in-flight read so a returning word always has a slot;
   // a same-cycle pop is deliberately not credited.
   assign issue      = reset_n && !bus.redirect && ((count + CW'(inflight)) < CW'(DEPTH));
   assign push       = inflight && !bus.redirect;
   assign head_valid = reset_n && (count != '0);
   assign pop        = head_valid && bus.code_ready;

   assign bus.mem_req    = issue;
   assign bus.mem_addr   = issue ? pc : '0;
   assign bus.code_valid = head_valid;
   assign bus.code       = head_valid ? word_q[rd_ptr] : '0;
   assign bus.code_pc    = head_valid ? pc_q[rd_ptr] : '0;
   assign bus.level      = reset_n ? count : '0;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else if (bus.redirect) begin
         pc       <= bus.redirect_pc;
         inflight <= 1'b0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            pc          <= pc + ADDR_W'(1);
            inflight_pc <= pc;
         end
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; occupancy alone decides what is visible.
   always_ff @(posedge clock) begin
      if (reset_n && push) begin
         word_q[wr_ptr] <= bus.mem_rdata;
         pc_q[wr_ptr]   <= inflight_pc;
      end
   end
endmodule
